// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, and queues {pc, word}
// pairs in a small FIFO handed to decode over valid/ready.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [ILEN-1:0] ins_mem [DEPTH];

  logic pop;
  logic push;
  logic target_ok;

  assign pop       = instr_valid & instr_ready;
  assign push      = (state == RUN) & ~redirect & ((count < CW'(DEPTH)) | pop);
  assign target_ok = (redirect_pc[1:0] == 2'b00);

  // FIFO storage is data only; validity lives in count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= pc;
      ins_mem[wr_ptr] <= imem_data;
    end
  end

  // PC, FIFO pointers and RUN/FAULT state; redirect overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (target_ok) begin
        pc    <= redirect_pc;
        state <= RUN;
      end else begin
        state <= FAULT;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs are pure functions of the registers above, never of inputs.
  assign imem_addr   = pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? ins_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]  : '0;
  assign fetch_fault = (state == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written reset and
// wrap sequences, then randomized traffic against a queue-based model.
module tb_instruction_fetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [63:0] HI_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ready;

  logic [63:0] addr_a, ipc_a, addr_b, ipc_b;
  logic [31:0] data_a, ins_a, data_b, ins_b;
  logic        valid_a, fault_a, valid_b, fault_b;

  assign data_a = {addr_a[31:2], 2'b11};
  assign data_b = {addr_b[31:2], 2'b11};

  instruction_fetch #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_data(data_a),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(valid_a),
    .instr_ready(ready), .instr(ins_a), .instr_pc(ipc_a), .fetch_fault(fault_a)
  );

  instruction_fetch #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(HI_PC), .DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_data(data_b),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(valid_b),
    .instr_ready(ready), .instr(ins_b), .instr_pc(ipc_b), .fetch_fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imem(input logic [63:0] a);
    return {a[31:2], 2'b11};
  endfunction

  // Directed vectors: inputs held for one cycle, outputs expected in that cycle.
  typedef struct packed {
    logic        rd;
    logic [63:0] rpc;
    logic        rdy;
    logic        v;
    logic [63:0] ipc;
    logic [31:0] ins;
    logic [63:0] addr;
    logic        flt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rd, input logic [63:0] rpc, input logic rdy, input logic v,
                     input logic [63:0] ipc, input logic [31:0] ins, input logic [63:0] addr,
                     input logic flt);
    vec_t e;
    e.rd = rd; e.rpc = rpc; e.rdy = rdy; e.v = v;
    e.ipc = ipc; e.ins = ins; e.addr = addr; e.flt = flt;
    tbl.push_back(e);
  endtask

  task automatic apply_row(input vec_t e, input int idx);
    @(negedge clk);
    redirect = e.rd; redirect_pc = e.rpc; ready = e.rdy;
    check($sformatf("row%0d.valid", idx), 64'(valid_a), 64'(e.v));
    check($sformatf("row%0d.instr_pc", idx), ipc_a, e.ipc);
    check($sformatf("row%0d.instr", idx), 64'(ins_a), 64'(e.ins));
    check($sformatf("row%0d.imem_addr", idx), addr_a, e.addr);
    check($sformatf("row%0d.fault", idx), 64'(fault_a), 64'(e.flt));
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Reference model: pending fetches as a queue of PCs, plus PC and fault flag.
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  logic        m_fault;

  task automatic model_check(input int cyc);
    logic        v;
    logic [63:0] hp;
    v  = (m_q.size() != 0);
    hp = v ? m_q[0] : 64'h0;
    check($sformatf("rand%0d.valid", cyc), 64'(valid_a), 64'(v));
    check($sformatf("rand%0d.instr_pc", cyc), ipc_a, hp);
    check($sformatf("rand%0d.instr", cyc), 64'(ins_a), v ? 64'(imem(hp)) : 64'h0);
    check($sformatf("rand%0d.imem_addr", cyc), addr_a, m_pc);
    check($sformatf("rand%0d.fault", cyc), 64'(fault_a), 64'(m_fault));
  endtask

  task automatic model_edge();
    logic do_pop;
    logic do_push;
    if (redirect) begin
      m_q.delete();
      if (redirect_pc[1:0] == 2'b00) begin
        m_pc = redirect_pc;
        m_fault = 1'b0;
      end else begin
        m_fault = 1'b1;
      end
    end else begin
      do_pop  = (m_q.size() != 0) && ready;
      do_push = !m_fault && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  initial begin
    logic [63:0] exp_b_pc [5];
    logic [63:0] t;
    checks = 0;
    failures = 0;

    // Startup streaming, stall with full FIFO, flush, misaligned fault and recovery.
    add(0, 64'h0,   1, 0, 64'h0,   32'h0,   64'h0,   0);
    add(0, 64'h0,   1, 1, 64'h0,   32'h3,   64'h4,   0);
    add(0, 64'h0,   1, 1, 64'h4,   32'h7,   64'h8,   0);
    add(0, 64'h0,   1, 1, 64'h8,   32'hB,   64'hC,   0);
    add(0, 64'h0,   1, 1, 64'hC,   32'hF,   64'h10,  0);
    add(1, 64'h0,   1, 1, 64'h10,  32'h13,  64'h14,  0);
    add(0, 64'h0,   0, 0, 64'h0,   32'h0,   64'h0,   0);
    add(0, 64'h0,   0, 1, 64'h0,   32'h3,   64'h4,   0);
    for (int i = 0; i < 4; i++) add(0, 64'h0, 0, 1, 64'h0, 32'h3, 64'h8, 0);
    add(0, 64'h0,   1, 1, 64'h0,   32'h3,   64'h8,   0);
    add(0, 64'h0,   1, 1, 64'h4,   32'h7,   64'hC,   0);
    add(0, 64'h0,   1, 1, 64'h8,   32'hB,   64'h10,  0);
    add(0, 64'h0,   0, 1, 64'hC,   32'hF,   64'h14,  0);
    add(1, 64'h100, 0, 1, 64'hC,   32'hF,   64'h14,  0);
    add(0, 64'h0,   0, 0, 64'h0,   32'h0,   64'h100, 0);
    add(0, 64'h0,   1, 1, 64'h100, 32'h103, 64'h104, 0);
    add(1, 64'h102, 1, 1, 64'h104, 32'h107, 64'h108, 0);
    for (int i = 0; i < 5; i++) add(0, 64'h0, 1, 0, 64'h0, 32'h0, 64'h108, 1);
    add(1, 64'h200, 1, 0, 64'h0,   32'h0,   64'h108, 1);
    add(0, 64'h0,   1, 0, 64'h0,   32'h0,   64'h200, 0);
    add(0, 64'h0,   1, 1, 64'h200, 32'h203, 64'h204, 0);

    do_reset();
    foreach (tbl[i]) apply_row(tbl[i], i);

    // PC wrap through 2^64 on the high-reset-PC instance.
    do_reset();
    exp_b_pc[0] = 64'h0; exp_b_pc[1] = HI_PC; exp_b_pc[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_b_pc[3] = 64'h0; exp_b_pc[4] = 64'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ready = 1'b1;
      check($sformatf("wrap%0d.valid", i), 64'(valid_b), (i == 0) ? 64'h0 : 64'h1);
      check($sformatf("wrap%0d.instr_pc", i), ipc_b, exp_b_pc[i]);
      check($sformatf("wrap%0d.instr", i), 64'(ins_b), (i == 0) ? 64'h0 : 64'(imem(exp_b_pc[i])));
      t = (i == 0) ? HI_PC : exp_b_pc[i] + 64'd4;
      check($sformatf("wrap%0d.imem_addr", i), addr_b, t);
      @(posedge clk);
    end

    // Asynchronous reset while the FIFO is full, then a clean restart.
    do_reset();
    repeat (3) begin
      @(negedge clk);
      ready = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    check("full.valid", 64'(valid_a), 64'h1);
    check("full.imem_addr", addr_a, 64'h8);
    rst_n = 1'b0;
    #1;
    check("async.valid", 64'(valid_a), 64'h0);
    check("async.imem_addr", addr_a, 64'h0);
    check("async.instr_pc", ipc_a, 64'h0);
    check("async.instr", 64'(ins_a), 64'h0);
    check("async.imem_addr_b", addr_b, HI_PC);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) apply_row(tbl[i], 100 + i);

    // Randomized traffic against the model.
    do_reset();
    m_pc = 64'h0; m_q.delete(); m_fault = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ready = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = {$urandom, $urandom};
        1: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) << 2);
        default: redirect_pc = {$urandom, $urandom} & ~64'h3;
      endcase
      model_check(c);
      @(posedge clk);
      model_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
